syn_weight_fetch: RTL
=====================

Name: syn_weight_fetch

Overview:
- Sits directly downstream of SRAM_8192x32_wrapper. It drives the SRAM's CS/WE/A/D pins and consumes its registered Q output.
- On each accepted presynaptic AER event, it sweeps the 32 words holding that neuron's synapse row. Each word is unpacked into 8 four-bit weights, giving one valid/ready beat per postsynaptic neuron to the neuron-update stage.
- In IDLE it also provides a host write path for loading the synapse memory.

Parameters:
- PRE_W, 8, presynaptic index width.
- POST_W, 8, postsynaptic index width.
- WGT_W, 4, weight width.
- DATA_W, 32, SRAM word width.
- ADDR_W, 13, SRAM address width. Constraint: ADDR_W = PRE_W + POST_W - log2(DATA_W/WGT_W).

Ports:
- CK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- EVT_VALID  in  1  presynaptic event valid.
- EVT_READY  out  1  = (state==IDLE) & ~CFG_WE.
- EVT_PRE  in  PRE_W  presynaptic neuron index.
- OUT_VALID  out  1  weight beat valid.
- OUT_READY  in  1  downstream accept.
- OUT_POST  out  POST_W  postsynaptic index = {word_idx, beat}.
- OUT_WGT  out  WGT_W  weight = wbuf[WGT_W*beat +: WGT_W].
- OUT_LAST  out  1  asserted on the beat with OUT_POST==255.
- CFG_WE  in  1  host write request.
- CFG_ADDR  in  ADDR_W  host write address.
- CFG_DATA  in  DATA_W  host write data.
- CFG_READY  out  1  = (state==IDLE); a write completes in the cycle CFG_WE & CFG_READY.
- SRAM_CS  out  1  SRAM chip select.
- SRAM_WE  out  1  SRAM write enable.
- SRAM_A  out  ADDR_W  SRAM address.
- SRAM_D  out  DATA_W  SRAM write data.
- SRAM_Q  in  DATA_W  SRAM read data; registered, valid 1 cycle after CS, held while CS=0.

Behaviour:
- Reset (asynchronous, any time including mid-sweep):
  - state=IDLE; pre, word_idx, beat, wbuf all = 0.
  - OUT_VALID=0, OUT_LAST=0, SRAM_CS=0, SRAM_WE=0, EVT_READY=1.
  - The sweep in progress is abandoned with no further beats; SRAM contents are untouched.
- SRAM pins are combinational from state and registers. SRAM_CS=0 unless stated below.
- Memory layout: word address = {pre, word_idx[4:0]}. Bits [4k+3:4k] of that word = weight for post neuron 8*word_idx+k.
- IDLE:
  - CFG_WE has priority: SRAM_CS=1, SRAM_WE=1, SRAM_A=CFG_ADDR, SRAM_D=CFG_DATA. EVT_READY=0 in that cycle.
  - Otherwise, on EVT_VALID & EVT_READY: latch pre; word_idx=0; go to FIRST.
- FIRST (1 cycle): SRAM_CS=1, SRAM_A={pre,0}; go to WAIT.
- WAIT (1 cycle):
  - wbuf<=SRAM_Q; beat=0.
  - SRAM_CS=1, SRAM_A={pre,1}, prefetching into SRAM Q, which holds it as the second buffer.
  - Go to EMIT.
- EMIT:
  - OUT_VALID=1; beat advances on each OUT_VALID & OUT_READY.
  - On the handshake at beat==7 with word_idx<31:
    - wbuf<=SRAM_Q; word_idx++; beat=0.
    - In the same cycle, if word_idx<30: SRAM_CS=1, SRAM_A={pre, word_idx+2}.
  - On the handshake at beat==7 with word_idx==31: OUT_LAST=1 on that beat; go to IDLE.
  - OUT_VALID=0 in the first IDLE cycle.
- Timing:
  - First OUT_VALID arrives 3 cycles after the event-accept edge.
  - Sustained rate is 1 beat/cycle with OUT_READY held high: 256 beats, next EVT_READY at accept+259.
- Backpressure: with OUT_READY=0, all outputs hold stable and SRAM_CS=0. Prefetched Q stays valid because the SRAM holds Qr while CS=0.
- Host writes are refused (CFG_READY=0) outside IDLE. The host must hold CFG_WE until accepted.
- EVT_VALID held outside IDLE is not accepted. The event is taken in the first IDLE cycle without CFG_WE.

Optional Feature:
- Macro SYN_WEIGHT_FETCH_SKIP_ZERO_EN.
- Defined:
  - In EMIT, a beat whose weight==0 and beat index !=255 is not presented. OUT_VALID=0 and the beat advances one position per cycle with no handshake.
  - Word-boundary load and prefetch rules still apply on the beat-7 advance.
  - Post 255 is always presented, even when zero, so OUT_LAST is always seen.
- Undefined: all 256 beats are presented.

Decomposition:
- Shared package/header snn_syn_defs:
  - Widths PRE_W, POST_W, WGT_W, DATA_W, ADDR_W.
  - BEATS_PER_WORD = DATA_W/WGT_W; WORDS_PER_ROW = 32.
  - State encodings IDLE=0, FIRST=1, WAIT=2, EMIT=3.
- One sub-module, syn_weight_unpack: combinational beat mux from wbuf and beat to OUT_WGT, plus the zero-skip detect.

Test Plan:
- Preload row 5 with words 0x76543210 for all 32 words; event pre=5 with OUT_READY=1 -> first OUT_VALID at accept+3; OUT_WGT sequence 0,1,…,7 repeated; OUT_POST 0..255; OUT_LAST only at 255; SRAM_A in FIRST=0x0A0.
- Same row with OUT_READY random 50% -> identical beat sequence, no drops or duplicates, outputs stable while stalled.
- CFG_WE and EVT_VALID both high in IDLE -> write to CFG_ADDR occurs first (SRAM_WE=1); event accepted the next cycle; CFG write issued mid-sweep -> CFG_READY=0 until IDLE.
- RST pulsed at beat 100 -> OUT_VALID=0 immediately; next event pre=7 starts a clean sweep from OUT_POST=0 with correct row-7 data.
- Back-to-back events pre=0 then pre=255 -> second sweep addresses 0x1FE0..0x1FFF; no data bleeds from row 0.
- With SYN_WEIGHT_FETCH_SKIP_ZERO_EN, row all zero except post 3 = 0x9 -> exactly two beats: (3,9) and (255,0,LAST).

Source files
------------

// File: rtl/snn_syn_defs.sv
// Shared widths, row geometry and fetch FSM state encoding for the synapse weight fetch block.
// Pure definitions: no logic, no latency.
// Backpressure: not applicable.
package snn_syn_defs;

   localparam int PRE_W          = 8;
   localparam int POST_W         = 8;
   localparam int WGT_W          = 4;
   localparam int DATA_W         = 32;
   localparam int ADDR_W         = 13;
   localparam int BEATS_PER_WORD = DATA_W / WGT_W;
   localparam int WORDS_PER_ROW  = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FIRST = 2'd1,
      S_WAIT  = 2'd2,
      S_EMIT  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/syn_weight_unpack.sv
// Selects the current weight nibble out of the buffered SRAM word and flags a zero weight.
// Latency: purely combinational.
// Backpressure: none; the caller holds wbuf/beat stable while stalled.
module syn_weight_unpack
   import snn_syn_defs::*;
#(
   parameter int DATA_W = snn_syn_defs::DATA_W,
   parameter int WGT_W  = snn_syn_defs::WGT_W,
   parameter int BEAT_W = $clog2(DATA_W / WGT_W)
) (
   input  logic [DATA_W-1:0] wbuf_i,
   input  logic [BEAT_W-1:0] beat_i,
   output logic [WGT_W-1:0]  wgt_o,
   output logic              zero_o
);

   // Beat k of a word lives in bits [WGT_W*k +: WGT_W].
   always_comb begin
      wgt_o  = wbuf_i[WGT_W*beat_i +: WGT_W];
      zero_o = (wgt_o == '0);
   end

endmodule

// File: rtl/syn_weight_fetch.sv
// Sweeps one presynaptic row (32 SRAM words) per accepted event and emits one weight beat per post neuron.
// Latency: first beat 3 cycles after the accept cycle; 1 beat/cycle sustained, EVT_READY again at accept+259.
// Backpressure: OUT_READY low freezes all outputs and keeps SRAM_CS low; the prefetched word waits in SRAM Q.
// Optional build macro SYN_WEIGHT_FETCH_SKIP_ZERO_EN: zero weights (except post 255) are skipped, one per cycle.
module syn_weight_fetch
   import snn_syn_defs::*;
#(
   parameter int PRE_W  = snn_syn_defs::PRE_W,
   parameter int POST_W = snn_syn_defs::POST_W,
   parameter int WGT_W  = snn_syn_defs::WGT_W,
   parameter int DATA_W = snn_syn_defs::DATA_W,
   parameter int ADDR_W = snn_syn_defs::ADDR_W
) (
   input  logic              CK,
   input  logic              RST,
   input  logic              EVT_VALID,
   output logic              EVT_READY,
   input  logic [PRE_W-1:0]  EVT_PRE,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [POST_W-1:0] OUT_POST,
   output logic [WGT_W-1:0]  OUT_WGT,
   output logic              OUT_LAST,
   input  logic              CFG_WE,
   input  logic [ADDR_W-1:0] CFG_ADDR,
   input  logic [DATA_W-1:0] CFG_DATA,
   output logic              CFG_READY,
   output logic              SRAM_CS,
   output logic              SRAM_WE,
   output logic [ADDR_W-1:0] SRAM_A,
   output logic [DATA_W-1:0] SRAM_D,
   input  logic [DATA_W-1:0] SRAM_Q
);

   localparam int BEAT_W = $clog2(DATA_W / WGT_W);
   localparam int WIDX_W = ADDR_W - PRE_W;

   localparam logic [BEAT_W-1:0] LAST_BEAT     = BEAT_W'(DATA_W / WGT_W - 1);
   localparam logic [WIDX_W-1:0] LAST_WORD     = WIDX_W'(WORDS_PER_ROW - 1);
   // Highest word index whose beat-7 advance still has a word two ahead to prefetch.
   localparam logic [WIDX_W-1:0] LAST_PREFETCH = WIDX_W'(WORDS_PER_ROW - 3);

`ifdef SYN_WEIGHT_FETCH_SKIP_ZERO_EN
   localparam bit SKIP_ZERO = 1'b1;
`else
   localparam bit SKIP_ZERO = 1'b0;
`endif

   fetch_state_e      state_q, state_d;
   logic [PRE_W-1:0]  pre_q,   pre_d;
   logic [WIDX_W-1:0] widx_q,  widx_d;
   logic [BEAT_W-1:0] beat_q,  beat_d;
   logic [DATA_W-1:0] wbuf_q,  wbuf_d;

   logic wgt_zero;
   logic is_last_beat;
   logic skip;
   logic advance;

   syn_weight_unpack #(
      .DATA_W (DATA_W),
      .WGT_W  (WGT_W),
      .BEAT_W (BEAT_W)
   ) u_unpack (
      .wbuf_i (wbuf_q),
      .beat_i (beat_q),
      .wgt_o  (OUT_WGT),
      .zero_o (wgt_zero)
   );

   // Handshake and output flags, all derived from registered state only.
   always_comb begin
      is_last_beat = (widx_q == LAST_WORD) && (beat_q == LAST_BEAT);
      // Post 255 is never skipped so the consumer always sees OUT_LAST.
      skip         = SKIP_ZERO && (state_q == S_EMIT) && wgt_zero && !is_last_beat;
      OUT_VALID    = (state_q == S_EMIT) && !skip;
      OUT_LAST     = (state_q == S_EMIT) && is_last_beat;
      advance      = skip || (OUT_VALID && OUT_READY);
      OUT_POST     = POST_W'({widx_q, beat_q});
      CFG_READY    = (state_q == S_IDLE);
      EVT_READY    = (state_q == S_IDLE) && !CFG_WE;
   end

   // Next-state and SRAM pin decode; SRAM pins stay idle unless a case below drives them.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      widx_d  = widx_q;
      beat_d  = beat_q;
      wbuf_d  = wbuf_q;
      SRAM_CS = 1'b0;
      SRAM_WE = 1'b0;
      SRAM_A  = '0;
      SRAM_D  = '0;
      case (state_q)
         S_IDLE: begin
            if (CFG_WE) begin
               // Host writes win over a pending event in the same cycle.
               SRAM_CS = 1'b1;
               SRAM_WE = 1'b1;
               SRAM_A  = CFG_ADDR;
               SRAM_D  = CFG_DATA;
            end else if (EVT_VALID) begin
               pre_d   = EVT_PRE;
               widx_d  = '0;
               state_d = S_FIRST;
            end
         end
         S_FIRST: begin
            SRAM_CS = 1'b1;
            SRAM_A  = {pre_q, WIDX_W'(0)};
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Word 0 lands in wbuf; word 1 is parked in SRAM Q as the second buffer.
            wbuf_d  = SRAM_Q;
            beat_d  = '0;
            SRAM_CS = 1'b1;
            SRAM_A  = {pre_q, WIDX_W'(1)};
            state_d = S_EMIT;
         end
         S_EMIT: begin
            if (advance) begin
               if (beat_q == LAST_BEAT) begin
                  if (widx_q != LAST_WORD) begin
                     wbuf_d = SRAM_Q;
                     widx_d = widx_q + WIDX_W'(1);
                     beat_d = '0;
                     if (widx_q <= LAST_PREFETCH) begin
                        SRAM_CS = 1'b1;
                        SRAM_A  = {pre_q, widx_q + WIDX_W'(2)};
                     end
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset abandons any sweep in flight.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         widx_q  <= '0;
         beat_q  <= '0;
         wbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         widx_q  <= widx_d;
         beat_q  <= beat_d;
         wbuf_q  <= wbuf_d;
      end
   end

endmodule
